pri_arbiter_lock: RTL and testbench
===================================

# pri_arbiter_lock

Registered, lock-holding priority arbiter for the pSLIP crossbar scheduler. It picks one of N requesters by highest request priority, breaking ties with a per-priority-level round-robin pointer. The grant is held until the owner releases it. Age counters promote starving requesters to top priority. It sits between the per-port VOQ request logic and the crossbar configuration register, and supports multi-cycle transfers.

## Interface
- N, 4: number of requesters (≥2)
- P, 16: number of priority levels (≥2)
- C, $clog2(P): priority field width
- AGE_MAX, 15: losing-cycle count at which a requester is promoted to level P-1 (≥1)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- en  in  1  block enable
- req  in  N  request vector
- pri_req  in  C×[0:N-1]  priority per requester; ignored where req[i]=0
- update_en  in  1  permits a pointer update on release
- release  in  1  owner ends its transfer
- gnt  out  N  registered one-hot grant
- any_gnt  out  1  |gnt
- gnt_idx  out  $clog2(N)  index of the owner; 0 when any_gnt=0
- gnt_pri  out  C  effective level the owner won at; 0 when idle
- pri_out  out  C×[0:N-1]  pri_out[i] = {C{gnt[i]}} & gnt_pri
- busy  out  1  FSM in LOCK

## Operation
- **FSM states:** IDLE and LOCK. Reset puts the FSM in IDLE with all outputs 0, all pointers ptr[0..P-1]=0 and all age[i]=0.
- **Effective level:** eff[i] = (age[i]==AGE_MAX) ? P-1 : pri_req[i].
- **Winning level:** L = max eff[i] over the requesters with req[i]=1.
- **Winner:** the first i with req[i]=1 and eff[i]=L, scanning cyclically upward from ptr[L] (ptr[L], ptr[L]+1, … mod N).
- **IDLE → LOCK:** when en=1 and |req=1, the winner is registered into gnt/gnt_idx/gnt_pri and the FSM goes to LOCK. Otherwise the FSM stays in IDLE.
- **LOCK, holding:** the grant holds and req/pri_req changes are ignored.
- **LOCK → IDLE:** on any of release=1, req[gnt_idx]=0 (implicit release) or en=0. The grant clears on the next edge.
- **Pointer update:** only on an explicit or implicit release with update_en=1 and en=1, ptr[gnt_pri] ← (gnt_idx+1) mod N. Other levels are untouched. Release caused by en=0 never updates a pointer.
- **Age, increment:** age[i] increments, saturating at AGE_MAX, in every cycle where en=1, req[i]=1 and i is neither the current owner nor the winner being registered this cycle.
- **Age, clear:** age[i] clears to 0 on the edge where i is registered as the owner, and when req[i]=0.
- **Age, freeze:** all ages hold while en=0.
- **Width rules:**
  - Pointer arithmetic is mod N. When N is not a power of 2, the wrap from N-1 must yield 0.
  - Age counters are $clog2(AGE_MAX+1) bits wide and never wrap.
- **Multiple starved requesters:** when several requesters are promoted at once, the normal round-robin scan of ptr[P-1] resolves them.

## Timing
- **Grant latency:** req is sampled in an IDLE cycle t; gnt is asserted from edge t+1 onward.
- **Release latency:** release sampled in cycle k clears gnt at edge k+1. The pointer updates at the same edge.
- **Grant-to-grant gap:** the FSM re-arbitrates in cycle k+1 and the next grant appears at k+2. There is exactly one idle cycle between owners. Back-to-back grants are not supported.
- **Simultaneous release and new requests:** requests arriving in the release cycle k are not considered until cycle k+1.
- **Release in the grant cycle:** release=1 in the same cycle the grant is first visible is legal and gives a 1-cycle grant.
- **release in IDLE:** has no effect.
- **en deasserted:** gnt=0 from the next edge. While en=0 there is no arbitration and no pointer or age change. On re-enable, arbitration resumes with the preserved pointers and ages.
- **Asynchronous reset mid-LOCK:** gnt, any_gnt, busy, gnt_idx, gnt_pri and pri_out go to 0 immediately, without waiting for a clock edge. Pointers and ages clear.
- **Output registering:** all outputs come directly from registers or from AND-gating of registers. There is no combinational path from req, pri_req or release to any output.

## Test plan
- **Basic priority:** N=4, req=4'b1111, pri_req={3,9,9,2}, update_en=1, release one cycle after each grant. Required grant sequence: 1, then 2, then 1 again (ptr[9] advances 2→3, then wraps), with gnt_pri=9 throughout. Requesters 0 and 3 age.
- **Starvation:** AGE_MAX=3, req=4'b0011, pri_req[0]=0, pri_req[1]=15, requester 1 re-requests continuously. After requester 0 has lost 3 cycles, it wins at effective level 15 with gnt_pri=15, and age[0] returns to 0.
- **Lock hold:** owner 2 granted. pri_req[3] is raised to 15 while release=0 for 10 cycles. gnt stays 4'b0100 and busy=1 throughout. release → gnt=0 at the next edge → gnt=4'b1000 one edge later.
- **Implicit release and update_en=0:** owner 1 drops req with update_en=0. gnt clears at the next edge and ptr[gnt_pri] is unchanged. A repeat request from 1 at the same level wins again.
- **Enable and reset:** en=0 during LOCK clears gnt next edge with the pointer unchanged and ages frozen. Re-enable resumes arbitration. Asserting reset asynchronously between edges zeroes all outputs immediately. After deassertion with req=4'b1111 at equal priority, the grant goes to requester 0.
- **N=3 wrap:** pointer after granting index 2 becomes 0, not 3, and the next tie at that level goes to requester 0.

Source files
------------

// File: rtl/pri_arbiter_lock.sv
// pri_arbiter_lock: registered priority arbiter with grant locking.
// Picks one requester by highest effective priority level, breaking ties
// with a round-robin pointer kept per level, and holds the grant until the
// owner lets go. Requesters that keep losing are aged up to the top level.
//
// Handshake: a grant is offered by registering gnt and entering LOCK; it is
// withdrawn when owner_release=1, the owner drops req, or en=0, and gnt
// clears on the following edge. Exactly one idle cycle separates owners.
//
// The owner's release input is called owner_release because "release" is a
// reserved word in SystemVerilog.
module pri_arbiter_lock #(
  parameter int N       = 4,
  parameter int P       = 16,
  parameter int C       = $clog2(P),
  parameter int AGE_MAX = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [N-1:0]          req,
  input  logic [C-1:0]          pri_req [N],
  input  logic                  update_en,
  input  logic                  owner_release,
  output logic [N-1:0]          gnt,
  output logic                  any_gnt,
  output logic [$clog2(N)-1:0]  gnt_idx,
  output logic [C-1:0]          gnt_pri,
  output logic [C-1:0]          pri_out [N],
  output logic                  busy
);

  localparam int IW = $clog2(N);
  localparam int AW = $clog2(AGE_MAX + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  logic [0:0]    state_q;
  logic [IW-1:0] ptr_q [P];
  logic [AW-1:0] age_q [N];

  logic [C-1:0]  eff [N];
  logic [C-1:0]  win_lvl;
  logic [IW-1:0] win_idx;
  logic          win_found;
  logic [IW:0]   cand;
  logic          grant_now;
  logic          owner_drop;
  logic          drop_now;
  logic [IW-1:0] ptr_next;

  // Effective level: a fully aged requester competes at the top level.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      eff[i] = (age_q[i] == AW'(AGE_MAX)) ? C'(P - 1) : pri_req[i];
    end
  end

  // Winning level: highest effective level among active requesters.
  always_comb begin
    win_lvl = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && (eff[i] > win_lvl)) begin
        win_lvl = eff[i];
      end
    end
  end

  // Winner: first requester at the winning level, scanning up from ptr[L].
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_q[win_lvl]} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) begin
        cand = cand - (IW+1)'(N);
      end
      if (!win_found && req[cand[IW-1:0]] && (eff[cand[IW-1:0]] == win_lvl)) begin
        win_found = 1'b1;
        win_idx   = cand[IW-1:0];
      end
    end
  end

  // Control terms: new grant, owner-driven release, any release, next pointer.
  always_comb begin
    grant_now  = (state_q == IDLE) && en && win_found;
    owner_drop = owner_release || !req[gnt_idx];
    drop_now   = (state_q == LOCK) && (owner_drop || !en);
    ptr_next   = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // FSM, grant registers and per-level round-robin pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt     <= '0;
      gnt_idx <= '0;
      gnt_pri <= '0;
      for (int l = 0; l < P; l++) begin
        ptr_q[l] <= '0;
      end
    end else begin
      if (grant_now) begin
        state_q <= LOCK;
        gnt     <= N'(1) << win_idx;
        gnt_idx <= win_idx;
        gnt_pri <= win_lvl;
      end else if (drop_now) begin
        state_q <= IDLE;
        gnt     <= '0;
        gnt_idx <= '0;
        gnt_pri <= '0;
        // Only an owner-driven release while enabled advances the pointer.
        if (en && update_en && owner_drop) begin
          ptr_q[gnt_pri] <= ptr_next;
        end
      end
    end
  end

  // Age counters: count losing cycles, clear on grant or idle, freeze when disabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        age_q[i] <= '0;
      end
    end else if (en) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          age_q[i] <= '0;
        end else if (grant_now && (win_idx == IW'(i))) begin
          age_q[i] <= '0;
        end else if ((state_q == LOCK) && (gnt_idx == IW'(i))) begin
          age_q[i] <= age_q[i];
        end else if (age_q[i] != AW'(AGE_MAX)) begin
          age_q[i] <= age_q[i] + 1'b1;
        end
      end
    end
  end

  // Outputs derived only from registered state.
  always_comb begin
    busy    = (state_q == LOCK);
    any_gnt = |gnt;
    for (int i = 0; i < N; i++) begin
      pri_out[i] = {C{gnt[i]}} & gnt_pri;
    end
  end

endmodule

// File: tb/tb_pri_arbiter_lock.sv
// Directed bench for pri_arbiter_lock: three instances cover the default
// configuration, a short aging limit and a non-power-of-2 requester count.
module tb_pri_arbiter_lock;

  // Clock and reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Main instance: N=4, P=16, AGE_MAX=15
  logic       m_en, m_upd, m_rel;
  logic [3:0] m_req;
  logic [3:0] m_pri [4];
  logic [3:0] m_gnt;
  logic       m_any, m_busy;
  logic [1:0] m_idx;
  logic [3:0] m_gpri;
  logic [3:0] m_pout [4];

  pri_arbiter_lock dut (
    .clk(clk), .reset(reset), .en(m_en), .req(m_req), .pri_req(m_pri),
    .update_en(m_upd), .owner_release(m_rel), .gnt(m_gnt), .any_gnt(m_any),
    .gnt_idx(m_idx), .gnt_pri(m_gpri), .pri_out(m_pout), .busy(m_busy)
  );

  // Starvation instance: AGE_MAX=3
  logic       s_en, s_upd, s_rel;
  logic [3:0] s_req;
  logic [3:0] s_pri [4];
  logic [3:0] s_gnt;
  logic       s_any, s_busy;
  logic [1:0] s_idx;
  logic [3:0] s_gpri;
  logic [3:0] s_pout [4];

  pri_arbiter_lock #(.AGE_MAX(3)) dut_s (
    .clk(clk), .reset(reset), .en(s_en), .req(s_req), .pri_req(s_pri),
    .update_en(s_upd), .owner_release(s_rel), .gnt(s_gnt), .any_gnt(s_any),
    .gnt_idx(s_idx), .gnt_pri(s_gpri), .pri_out(s_pout), .busy(s_busy)
  );

  // Wrap instance: N=3
  logic       w_en, w_upd, w_rel;
  logic [2:0] w_req;
  logic [3:0] w_pri [3];
  logic [2:0] w_gnt;
  logic       w_any, w_busy;
  logic [1:0] w_idx;
  logic [3:0] w_gpri;
  logic [3:0] w_pout [3];

  pri_arbiter_lock #(.N(3)) dut_w (
    .clk(clk), .reset(reset), .en(w_en), .req(w_req), .pri_req(w_pri),
    .update_en(w_upd), .owner_release(w_rel), .gnt(w_gnt), .any_gnt(w_any),
    .gnt_idx(w_idx), .gnt_pri(w_gpri), .pri_out(w_pout), .busy(w_busy)
  );

  // Scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; return 1 time unit after it, away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_en = 1'b1; m_upd = 1'b1; m_rel = 1'b0; m_req = '0;
    s_en = 1'b1; s_upd = 1'b1; s_rel = 1'b0; s_req = '0;
    w_en = 1'b1; w_upd = 1'b1; w_rel = 1'b0; w_req = '0;
    for (int i = 0; i < 4; i++) begin
      m_pri[i] = '0;
      s_pri[i] = '0;
    end
    for (int i = 0; i < 3; i++) w_pri[i] = '0;

    // Reset state
    tick();
    tick();
    check("rst_gnt", 32'(m_gnt), 32'h0);
    check("rst_busy", 32'(m_busy), 32'h0);
    check("rst_any", 32'(m_any), 32'h0);
    check("rst_idx", 32'(m_idx), 32'h0);
    check("rst_gpri", 32'(m_gpri), 32'h0);
    reset = 1'b1;

    // Basic priority: levels {3,9,9,2}, ties at 9 resolved round-robin
    m_pri[0] = 4'd3; m_pri[1] = 4'd9; m_pri[2] = 4'd9; m_pri[3] = 4'd2;
    m_req = 4'b1111;
    tick();
    check("basic_g1", 32'(m_gnt), 32'h2);
    check("basic_g1_pri", 32'(m_gpri), 32'd9);
    check("basic_g1_busy", 32'(m_busy), 32'h1);
    check("basic_g1_pout", 32'(m_pout[1]), 32'd9);
    check("basic_g1_pout0", 32'(m_pout[0]), 32'd0);
    m_rel = 1'b1;
    tick();
    check("basic_rel1", 32'(m_gnt), 32'h0);
    check("basic_ptr9_a", 32'(dut.ptr_q[9]), 32'd2);
    m_rel = 1'b0;
    tick();
    check("basic_g2", 32'(m_gnt), 32'h4);
    check("basic_g2_idx", 32'(m_idx), 32'd2);
    m_rel = 1'b1;
    tick();
    check("basic_ptr9_b", 32'(dut.ptr_q[9]), 32'd3);
    m_rel = 1'b0;
    tick();
    check("basic_g3", 32'(m_gnt), 32'h2);
    check("basic_g3_pri", 32'(m_gpri), 32'd9);
    check("basic_age0", 32'(dut.age_q[0]), 32'd5);
    check("basic_age3", 32'(dut.age_q[3]), 32'd5);
    m_rel = 1'b1;
    tick();
    m_rel = 1'b0;
    m_req = '0;
    tick();

    // Lock hold: owner 2 keeps the grant while a level-15 request waits
    m_pri[2] = 4'd9;
    m_req = 4'b0100;
    tick();
    check("lock_g", 32'(m_gnt), 32'h4);
    m_req = 4'b1100;
    m_pri[3] = 4'd15;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("lock_hold_gnt", 32'(m_gnt), 32'h4);
      check("lock_hold_busy", 32'(m_busy), 32'h1);
    end
    m_rel = 1'b1;
    tick();
    check("lock_rel", 32'(m_gnt), 32'h0);
    m_rel = 1'b0;
    tick();
    check("lock_next", 32'(m_gnt), 32'h8);
    check("lock_next_pri", 32'(m_gpri), 32'd15);
    m_rel = 1'b1;
    m_req = '0;
    tick();
    m_rel = 1'b0;
    tick();

    // Implicit release with update_en=0 leaves ptr[4] alone
    m_upd = 1'b0;
    m_pri[1] = 4'd4; m_pri[2] = 4'd4;
    m_req = 4'b0010;
    tick();
    check("impl_g", 32'(m_gnt), 32'h2);
    check("impl_g_pri", 32'(m_gpri), 32'd4);
    m_req = 4'b0000;
    tick();
    check("impl_clear", 32'(m_gnt), 32'h0);
    check("impl_ptr4", 32'(dut.ptr_q[4]), 32'd0);
    m_req = 4'b0110;
    tick();
    check("impl_again", 32'(m_gnt), 32'h2);
    check("impl_again_idx", 32'(m_idx), 32'd1);
    m_req = 4'b0000;
    tick();
    m_upd = 1'b1;
    tick();

    // Starvation: requester 0 at level 0 is promoted after 3 lost cycles
    s_pri[0] = 4'd0; s_pri[1] = 4'd15;
    s_req = 4'b0011;
    tick();
    check("starve_g1", 32'(s_gnt), 32'h2);
    s_rel = 1'b1;
    tick();
    s_rel = 1'b0;
    tick();
    check("starve_g2", 32'(s_gnt), 32'h2);
    check("starve_age3", 32'(dut_s.age_q[0]), 32'd3);
    s_rel = 1'b1;
    tick();
    s_rel = 1'b0;
    tick();
    check("starve_win", 32'(s_gnt), 32'h1);
    check("starve_win_pri", 32'(s_gpri), 32'd15);
    check("starve_pout0", 32'(s_pout[0]), 32'd15);
    check("starve_age0", 32'(dut_s.age_q[0]), 32'd0);
    s_rel = 1'b1;
    s_req = '0;
    tick();
    s_rel = 1'b0;

    // N=3 wrap: granting index 2 returns ptr[5] to 0
    for (int i = 0; i < 3; i++) w_pri[i] = 4'd5;
    w_req = 3'b010;
    tick();
    check("wrap_g1", 32'(w_gnt), 32'h2);
    w_rel = 1'b1;
    tick();
    check("wrap_ptr_a", 32'(dut_w.ptr_q[5]), 32'd2);
    w_rel = 1'b0;
    w_req = 3'b100;
    tick();
    check("wrap_g2_idx", 32'(w_idx), 32'd2);
    w_rel = 1'b1;
    tick();
    check("wrap_ptr_b", 32'(dut_w.ptr_q[5]), 32'd0);
    w_rel = 1'b0;
    w_req = 3'b111;
    tick();
    check("wrap_tie", 32'(w_gnt), 32'h1);
    check("wrap_tie_idx", 32'(w_idx), 32'd0);
    w_rel = 1'b1;
    w_req = '0;
    tick();
    w_rel = 1'b0;

    // Enable: en=0 drops the grant, freezes ages and pointers
    for (int i = 0; i < 4; i++) m_pri[i] = 4'd7;
    m_req = 4'b1111;
    tick();
    check("en_g1", 32'(m_gnt), 32'h1);
    m_en = 1'b0;
    tick();
    check("en_off_gnt", 32'(m_gnt), 32'h0);
    check("en_off_busy", 32'(m_busy), 32'h0);
    check("en_off_ptr7", 32'(dut.ptr_q[7]), 32'd0);
    check("en_off_age1", 32'(dut.age_q[1]), 32'd1);
    tick();
    check("en_off2_gnt", 32'(m_gnt), 32'h0);
    check("en_off2_age1", 32'(dut.age_q[1]), 32'd1);
    m_en = 1'b1;
    tick();
    check("en_on_gnt", 32'(m_gnt), 32'h1);
    check("en_on_age1", 32'(dut.age_q[1]), 32'd2);
    m_rel = 1'b1;
    tick();
    check("en_ptr7", 32'(dut.ptr_q[7]), 32'd1);
    m_rel = 1'b0;
    tick();
    check("en_next", 32'(m_gnt), 32'h2);

    // Asynchronous reset between edges while in LOCK
    #2;
    reset = 1'b0;
    #1;
    check("areset_gnt", 32'(m_gnt), 32'h0);
    check("areset_any", 32'(m_any), 32'h0);
    check("areset_busy", 32'(m_busy), 32'h0);
    check("areset_idx", 32'(m_idx), 32'h0);
    check("areset_gpri", 32'(m_gpri), 32'h0);
    check("areset_pout1", 32'(m_pout[1]), 32'h0);
    check("areset_ptr7", 32'(dut.ptr_q[7]), 32'd0);
    check("areset_age2", 32'(dut.age_q[2]), 32'd0);
    #1;
    reset = 1'b1;
    tick();
    check("post_reset_gnt", 32'(m_gnt), 32'h1);
    check("post_reset_idx", 32'(m_idx), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
